// File: rtl/host_write_engine.sv
// Host-memory write engine: turns AFU result lines into c1 cache-line write requests
// relative to a captured host buffer base, and tracks write responses so the AFU can flush.
module host_write_engine #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_buf_addr_valid,
  input  logic [41:0]        i_buf_addr,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [15:0]        i_wr_offset,
  input  logic [511:0]       i_wr_data,
  input  logic               i_flush,
  output logic               o_flush_done,
  input  logic               i_c1_almfull,
  output logic               o_c1_req_valid,
  output logic [41:0]        o_c1_req_addr,
  output logic [511:0]       o_c1_req_data,
  output logic [15:0]        o_c1_req_mdata,
  input  logic               i_c1_rsp_valid,
  output logic [CNT_W-1:0]   o_outstanding,
  output logic               o_error
);

  typedef enum logic [1:0] {
    WAIT_BUF = 2'd0,
    ACCEPT   = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t             r_state;
  logic [41:0]        r_base;
  logic [15:0]        r_tag;
  logic               r_req_valid;
  logic [41:0]        r_req_addr;
  logic [511:0]       r_req_data;
  logic [15:0]        r_req_mdata;
  logic [CNT_W-1:0]   r_outstanding;
  logic               r_error;

  logic [CNT_W:0]     w_credit_sum;
  logic               w_ready;
  logic               w_handshake;
  logic               w_drained;

  // A registered request counts against the credit limit before it reaches the counter.
  assign w_credit_sum = {1'b0, r_outstanding} + (CNT_W+1)'(r_req_valid);
  assign w_ready      = (r_state == ACCEPT) && !i_c1_almfull &&
                        (w_credit_sum < (CNT_W+1)'(MAX_OUTSTANDING));
  assign w_handshake  = i_wr_valid && w_ready;
  assign w_drained    = (r_state == DRAIN) && (r_outstanding == '0) && !r_req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= WAIT_BUF;
      r_base        <= '0;
      r_tag         <= '0;
      r_req_valid   <= 1'b0;
      r_req_addr    <= '0;
      r_req_data    <= '0;
      r_req_mdata   <= '0;
      r_outstanding <= '0;
      r_error       <= 1'b0;
    end else begin
      r_req_valid <= w_handshake;
      if (w_handshake) begin
        r_req_addr  <= r_base + 42'(i_wr_offset);
        r_req_data  <= i_wr_data;
        r_req_mdata <= r_tag;
        r_tag       <= r_tag + 16'd1;
      end

      // Issue and response in the same cycle cancel; a stray response flags an error.
      case ({r_req_valid, i_c1_rsp_valid})
        2'b10: r_outstanding <= r_outstanding + 1'b1;
        2'b01: begin
          if (r_outstanding == '0) r_error <= 1'b1;
          else                     r_outstanding <= r_outstanding - 1'b1;
        end
        default: ;
      endcase

      case (r_state)
        WAIT_BUF: begin
          if (i_buf_addr_valid) begin
            r_base  <= i_buf_addr;
            r_state <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (i_flush) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drained) r_state <= ACCEPT;
        end
        default: r_state <= WAIT_BUF;
      endcase
    end
  end

  assign o_wr_ready     = w_ready;
  assign o_flush_done   = w_drained;
  assign o_c1_req_valid = r_req_valid;
  assign o_c1_req_addr  = r_req_addr;
  assign o_c1_req_data  = r_req_data;
  assign o_c1_req_mdata = r_req_mdata;
  assign o_outstanding  = r_outstanding;
  assign o_error        = r_error;

endmodule

// File: tb/tb_host_write_engine.sv
// Randomized bench for host_write_engine with a cycle-level reference model of the
// write/credit/flush rules, plus directed sequences for the boundary cases.
module tb_host_write_engine;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_buf_addr_valid, i_wr_valid, i_flush, i_c1_almfull, i_c1_rsp_valid;
  logic [41:0] i_buf_addr;
  logic [15:0] i_wr_offset;
  logic [511:0] i_wr_data;
  logic o_wr_ready, o_flush_done, o_c1_req_valid, o_error;
  logic [41:0] o_c1_req_addr;
  logic [511:0] o_c1_req_data;
  logic [15:0] o_c1_req_mdata;
  logic [CW-1:0] o_outstanding;

  host_write_engine #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_buf_addr_valid(i_buf_addr_valid), .i_buf_addr(i_buf_addr),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_offset(i_wr_offset), .i_wr_data(i_wr_data),
    .i_flush(i_flush), .o_flush_done(o_flush_done),
    .i_c1_almfull(i_c1_almfull),
    .o_c1_req_valid(o_c1_req_valid), .o_c1_req_addr(o_c1_req_addr),
    .o_c1_req_data(o_c1_req_data), .o_c1_req_mdata(o_c1_req_mdata),
    .i_c1_rsp_valid(i_c1_rsp_valid),
    .o_outstanding(o_outstanding), .o_error(o_error)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting for base, 1 = accepting, 2 = draining.
  int          m_mode;
  logic [41:0] m_base;
  int          m_tag;
  int          m_out;
  bit          m_pend;
  logic [41:0] m_addr;
  logic [511:0] m_data;
  logic [15:0] m_mdata;
  bit          m_err;

  int n_total = 0;
  int n_pass  = 0;
  int issued_cnt;
  int done_cnt;
  bit wrap_seen;
  logic [15:0] prev_mdata;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_base = '0; m_tag = 0; m_out = 0; m_pend = 0;
    m_addr = '0; m_data = '0; m_mdata = '0; m_err = 0;
  endtask

  // Called at a falling edge with inputs already applied; checks, advances model, waits a cycle.
  task automatic tick();
    bit exp_ready, exp_fd, hs;
    int n;
    logic [42:0] sum;
    #1;
    exp_ready = (m_mode == 1) && !i_c1_almfull && ((m_out + int'(m_pend)) < MAXO);
    exp_fd    = (m_mode == 2) && (m_out == 0) && !m_pend;
    check("wr_ready", 512'(o_wr_ready), 512'(exp_ready));
    check("flush_done", 512'(o_flush_done), 512'(exp_fd));
    check("req_valid", 512'(o_c1_req_valid), 512'(m_pend));
    if (m_pend) begin
      check("req_addr", 512'(o_c1_req_addr), 512'(m_addr));
      check("req_data", o_c1_req_data, m_data);
      check("req_mdata", 512'(o_c1_req_mdata), 512'(m_mdata));
      issued_cnt++;
      if (o_c1_req_mdata == 16'h0000 && prev_mdata == 16'hFFFF) wrap_seen = 1;
      prev_mdata = o_c1_req_mdata;
    end
    check("outstanding", 512'(o_outstanding), 512'(m_out));
    check("error", 512'(o_error), 512'(m_err));
    if (o_flush_done) done_cnt++;

    hs = i_wr_valid && exp_ready;
    n = m_out + int'(m_pend);
    if (i_c1_rsp_valid) begin
      if (n == 0) m_err = 1;
      else n--;
    end
    m_out  = n;
    m_pend = hs;
    if (hs) begin
      sum     = {1'b0, m_base} + {27'd0, i_wr_offset};
      m_addr  = sum[41:0];
      m_data  = i_wr_data;
      m_mdata = 16'(m_tag);
      m_tag   = (m_tag + 1) % 65536;
    end
    case (m_mode)
      0: if (i_buf_addr_valid) begin m_base = i_buf_addr; m_mode = 1; end
      1: if (i_flush) m_mode = 2;
      default: if (exp_fd) m_mode = 1;
    endcase
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_buf_addr_valid = 0; i_buf_addr = '0; i_wr_valid = 0; i_wr_offset = '0;
    i_wr_data = '0; i_flush = 0; i_c1_almfull = 0; i_c1_rsp_valid = 0;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_ready", 512'(o_wr_ready), 512'(0));
    check("rst_req_valid", 512'(o_c1_req_valid), 512'(0));
    check("rst_req_addr", 512'(o_c1_req_addr), 512'(0));
    check("rst_req_data", o_c1_req_data, 512'(0));
    check("rst_req_mdata", 512'(o_c1_req_mdata), 512'(0));
    check("rst_outstanding", 512'(o_outstanding), 512'(0));
    check("rst_flush_done", 512'(o_flush_done), 512'(0));
    check("rst_error", 512'(o_error), 512'(0));
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drain_to_zero();
    i_wr_valid = 0;
    for (int k = 0; k < 20 && (m_out + int'(m_pend)) > 0; k++) begin
      i_c1_rsp_valid = 1; tick();
    end
    i_c1_rsp_valid = 0;
    for (int k = 0; k < 4 && m_mode != 1; k++) tick();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    prev_mdata = 16'h0000;
    wrap_seen = 0;
    issued_cnt = 0;
    done_cnt = 0;
    repeat (2) @(negedge clk);
    async_reset();

    // Writes and flush are ignored until the base is valid
    i_wr_valid = 1; i_flush = 1; tick();
    i_flush = 0; tick(); tick();

    // Base capture and a single write: offset 5 from 0x1000
    i_wr_valid = 0; i_buf_addr_valid = 1; i_buf_addr = 42'h1000; tick();
    i_buf_addr = 42'h2A5A5; // must not be re-sampled
    i_wr_valid = 1; i_wr_offset = 16'd5; i_wr_data = {16{32'hA5A5_0001}}; tick();
    i_wr_valid = 0; tick(); tick();
    i_c1_rsp_valid = 1; tick();
    i_c1_rsp_valid = 0; tick();

    // Credit limit: 8 cycles of offered writes, no responses
    issued_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      i_wr_valid = 1; i_wr_offset = 16'($urandom); i_wr_data = rand_line(); tick();
    end
    i_wr_valid = 0; tick();
    check("credit_issued", 512'(issued_cnt), 512'(MAXO));

    // Simultaneous issue and response keeps the count
    i_c1_rsp_valid = 1; tick();
    i_wr_valid = 1; i_wr_data = rand_line(); tick();
    i_wr_valid = 0; tick();
    tick();
    i_c1_rsp_valid = 0;
    drain_to_zero();

    // Almost-full alone blocks acceptance
    i_c1_almfull = 1; i_wr_valid = 1;
    repeat (3) tick();
    i_c1_almfull = 0; i_wr_valid = 0;

    // Flush with 3 writes in flight and delayed responses
    for (int k = 0; k < 3; k++) begin
      i_wr_valid = 1; i_wr_offset = 16'(k); i_wr_data = rand_line(); tick();
    end
    i_wr_valid = 0; i_flush = 1; tick();
    i_flush = 0; done_cnt = 0;
    i_wr_valid = 1;
    repeat (10) tick();
    i_wr_valid = 0;
    i_c1_rsp_valid = 1; repeat (3) tick();
    i_c1_rsp_valid = 0; repeat (3) tick();
    check("flush_done_pulses", 512'(done_cnt), 512'(1));

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      i_buf_addr_valid = 1'($urandom_range(0, 1));
      i_buf_addr       = {10'($urandom), 32'($urandom)};
      i_wr_valid       = ($urandom_range(0, 99) < 70);
      i_wr_offset      = 16'($urandom);
      i_wr_data        = rand_line();
      i_flush          = ($urandom_range(0, 99) < 4);
      i_c1_almfull     = ($urandom_range(0, 99) < 20);
      i_c1_rsp_valid   = ((m_out + int'(m_pend)) > 0) && ($urandom_range(0, 99) < 45);
      tick();
    end
    idle_inputs();
    drain_to_zero();

    // Stray response sets a sticky error
    i_c1_rsp_valid = 1; tick();
    i_c1_rsp_valid = 0; repeat (3) tick();
    check("error_sticky", 512'(o_error), 512'(1));

    // Reset in the middle of a drain
    i_wr_valid = 1; tick(); tick();
    i_wr_valid = 0; i_flush = 1; tick();
    i_flush = 0; tick();
    async_reset();
    i_wr_valid = 1; repeat (4) tick();

    // Address wrap and tag wrap across 65537 writes
    i_buf_addr_valid = 1; i_buf_addr = 42'h3FF_FFFF_FFFF; i_wr_valid = 0; tick();
    i_buf_addr_valid = 0;
    i_wr_valid = 1; i_wr_offset = 16'd2; i_wr_data = rand_line(); tick();
    check("addr_wrap", 512'(o_c1_req_addr), 512'(42'h001));
    wrap_seen = 0;
    for (int k = 1; k < 65537; k++) begin
      i_wr_offset = 16'($urandom);
      i_wr_data[31:0] = 32'($urandom);
      i_c1_rsp_valid = (m_out + int'(m_pend)) > 0;
      tick();
    end
    i_wr_valid = 0;
    i_c1_rsp_valid = (m_out + int'(m_pend)) > 0; tick();
    i_c1_rsp_valid = 0; tick();
    check("mdata_wrap", 512'(wrap_seen), 512'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/host_write_engine.md
# host_write_engine

Host-memory write engine for the AFU. It accepts 512-bit result lines from the AFU datapath over a valid/ready handshake and turns each into a CCI-P channel-1 (c1) cache-line write request, addressed relative to the host buffer base. It tracks write responses so the AFU can flush, meaning wait until every issued write is acknowledged, before reporting completion. It is the write-side counterpart of the memory read path that fetches instructions, and sits between the AFU control FSM and the c1 TX/RX ports.

## Interface
- MAX_OUTSTANDING, 64: maximum unacknowledged c1 writes (power of 2, ≤ 256)
- CNT_W, $clog2(MAX_OUTSTANDING)+1: width of outstanding counter

- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- buf_addr_valid  in  1  host buffer base is valid (level, from memory block)
- buf_addr  in  42  host buffer base, cache-line address
- wr_valid  in  1  AFU offers a write
- wr_ready  out  1  engine accepts write this cycle
- wr_offset  in  16  cache-line offset from base
- wr_data  in  512  line to write
- flush  in  1  single-cycle request: drain all outstanding writes
- flush_done  out  1  single-cycle pulse: flush complete
- c1_almfull  in  1  c1 TX almost-full back-pressure
- c1_req_valid  out  1  c1 write request valid (one cycle per request)
- c1_req_addr  out  42  request address
- c1_req_data  out  512  request data
- c1_req_mdata  out  16  request tag
- c1_rsp_valid  in  1  c1 write response received
- outstanding  out  CNT_W  issued-but-unacknowledged writes
- error  out  1  sticky: response arrived with outstanding == 0

## Operation
- States: WAIT_BUF, ACCEPT, DRAIN.
- WAIT_BUF: wr_ready = 0. When buf_addr_valid = 1, capture buf_addr and go to ACCEPT. buf_addr is not re-sampled after capture until reset.
- ACCEPT: wr_ready = !c1_almfull && (outstanding + c1_req_valid) < MAX_OUTSTANDING. On wr_valid && wr_ready, register the request.
  - c1_req_addr = base + zero-extended wr_offset, mod 2^42 (wraps, no error).
  - c1_req_data = wr_data.
  - c1_req_mdata = tag counter. The tag counter starts at 0, increments per issued request and wraps 0xFFFF→0.
- A flush while in ACCEPT goes to DRAIN. If flush and a write handshake occur in the same cycle, the write is accepted first and then counted in the drain.
- A flush in WAIT_BUF or DRAIN is ignored.
- DRAIN: wr_ready = 0. When outstanding == 0 and c1_req_valid == 0, pulse flush_done for one cycle and return to ACCEPT in that same cycle.
- Outstanding counter:
  - +1 in the cycle c1_req_valid = 1.
  - −1 on c1_rsp_valid.
  - Both in the same cycle: no change.
  - c1_rsp_valid while outstanding == 0 (and no issue that cycle): counter holds at 0 and error sets. error clears only on reset.
- Response mdata is not checked. Responses may return out of order.

## Timing
- Reset values:
  - state WAIT_BUF; stored base 0; tag counter 0.
  - wr_ready 0, c1_req_valid 0, c1_req_addr 0, c1_req_data 0, c1_req_mdata 0.
  - outstanding 0, flush_done 0, error 0.
- wr_ready is combinational from state, c1_almfull and registered counters. It has no combinational path from wr_valid.
- Latency: a handshake in cycle N drives c1_req_valid = 1 in cycle N+1, for exactly one cycle.
- Throughput: one write per cycle while c1_almfull = 0 and the credit limit is not reached.
- c1_almfull is sampled only through wr_ready. A request already registered is still issued the next cycle, which is permitted by the almost-full margin.
- Credit limit: the (outstanding + c1_req_valid) term ensures outstanding never exceeds MAX_OUTSTANDING.
- buf_addr_valid → ACCEPT in one cycle; wr_ready may be 1 in the cycle after capture.
- flush_done is asserted at the earliest one cycle after flush, and in the same cycle the drain condition is met.
- Reset mid-operation: all state is discarded immediately (async). In-flight responses after reset may set error and are the system's responsibility.

## Test plan
- Base capture and issue: buf_addr = 0x1000, one write with offset 5 and data pattern A → in the next cycle, c1_req_valid = 1 for one cycle, addr 0x1005, data A, mdata 0; outstanding goes to 1, then to 0 after the response.
- Back-pressure and credit: MAX_OUTSTANDING = 4, no responses, wr_valid held high for 8 cycles → exactly 4 requests issued and wr_ready = 0 thereafter. Asserting c1_almfull alone forces wr_ready = 0 within the same cycle.
- Simultaneous issue/response: outstanding = 2, a response and an issue in the same cycle → outstanding stays 2. A response alone → 1.
- Flush: 3 writes issued, flush pulsed, responses delayed 10 cycles → wr_ready = 0 during drain; one flush_done pulse in the cycle the 3rd response brings outstanding to 0; state back to ACCEPT.
- Wrap-around: buf_addr = 0x3FFFFFFFFFF with offset 2 → addr 0x001. 65537 issued writes → mdata sequence wraps from 0xFFFF to 0x0000.
- Error and reset: a response with outstanding = 0 → error = 1 and stays set. Asserting rst_n low mid-drain → all outputs return to reset values asynchronously, and after release the engine waits in WAIT_BUF.
